ex3_word_converter_ctrl: RTL

- Sequencer that converts a packed multi-digit Excess-3 word to binary.
- Uses one shared single-digit Excess-3 decoder, one digit per clock, MSB digit first.
- Accumulates acc = acc*10 + digit. Sits between a valid/ready producer (keypad/BCD front end) and a binary consumer (display/ALU path).
- Flags any nibble that is not a legal Excess-3 code.

---
 rtl/ex3_pkg.sv | 30 +++
 rtl/ex3_digit_decode.sv | 15 +
 rtl/ex3_word_converter_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/ex3_pkg.sv
// Shared definitions for the Excess-3 word converter: code limits, FSM states
// and a helper giving the narrowest result width for a digit count.
package ex3_pkg;

    localparam logic [3:0] EX3_OFFSET = 4'd3;
    localparam logic [3:0] EX3_MIN    = 4'h3;
    localparam logic [3:0] EX3_MAX    = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // Smallest BIN_W such that 2^BIN_W > 10^digits - 1.
    function automatic int unsigned min_bin_w(input int unsigned digits);
        longint unsigned max_val = 1;
        int unsigned     width   = 0;
        for (int unsigned i = 0; i < digits; i++) begin
            max_val = max_val * 10;
        end
        max_val = max_val - 1;
        while (max_val != 0) begin
            width++;
            max_val = max_val >> 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/ex3_digit_decode.sv
// Single-digit Excess-3 decoder; illegal codes report legal=0 and digit=0.
module ex3_digit_decode
    import ex3_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    always_comb begin
        o_legal = (i_nibble >= EX3_MIN) && (i_nibble <= EX3_MAX);
        o_digit = o_legal ? (i_nibble - EX3_OFFSET) : 4'd0;
    end

endmodule

// File: rtl/ex3_word_converter_ctrl.sv
// Converts a packed Excess-3 word to binary, one digit per clock, MSB first.
// Optional EX3_EARLY_ABORT_EN: stop at the first illegal nibble.
module ex3_word_converter_ctrl
    import ex3_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_ex3,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      out_binary,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [4*DIGITS-1:0] r_word;
    logic [BIN_W-1:0]    r_acc;
    logic                r_err;
    logic [IDX_W-1:0]    r_idx;

    logic [3:0]          w_nibble;
    logic [3:0]          w_digit;
    logic                w_legal;
    logic                w_abort;
    logic [BIN_W-1:0]    w_acc_next;

    always_comb begin
        w_nibble = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_word[4*i +: 4];
            end
        end
    end

    ex3_digit_decode u_decode (
        .i_nibble (w_nibble),
        .o_digit  (w_digit),
        .o_legal  (w_legal)
    );

    // acc*10 + d as shift-add; BIN_W is sized so this never overflows.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_digit);

`ifdef EX3_EARLY_ABORT_EN
    assign w_abort = ~w_legal;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = CONV;
            CONV:    if ((r_idx == '0) || w_abort) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_acc  <= '0;
            r_err  <= 1'b0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word <= in_ex3;
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                        r_idx  <= IDX_W'(DIGITS - 1);
                    end
                end
                CONV: begin
                    if (!w_abort) r_acc <= w_acc_next;
                    if (!w_legal) r_err <= 1'b1;
                    r_idx <= r_idx - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign out_binary = r_acc;
    assign out_err    = r_err;

endmodule
